expr_gen: RTL and testbench

- Character-stream generator for the digit/operator/parenthesis expression grammar. This is the producer side of the stream that our expression recognizer consumes.
- Emits one 8-bit ASCII character per accepted handshake.
- Every emitted string is a complete, legal expression. Content is pseudo-random, driven by a seeded 16-bit LFSR.
- Used as a stimulus source for recognizer benches and as a self-checking loopback partner on the board.

---
 rtl/expr_gen_pkg.sv | 29 ++
 rtl/expr_lfsr16.sv | 27 ++
 rtl/expr_gen.sv | 128 ++++++++++++
 tb/tb_expr_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_gen_pkg.sv
// Shared constants for the expression generator and recognizer benches:
// ASCII characters, FSM state encoding and the LFSR feedback taps.
package expr_gen_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_LPAR = 8'h28;
  localparam logic [7:0] CH_RPAR = 8'h29;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TERM   = 3'd1,
    S_GDIG   = 3'd2,
    S_GOP    = 3'd3,
    S_GCLOSE = 3'd4,
    S_OP     = 3'd5
  } state_e;

  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/expr_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and single-step advance.
module expr_lfsr16
  import expr_gen_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      lfsr_q <= 16'h0000;
    end else if (load_i) begin
      lfsr_q <= seed_i;
    end else if (adv_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/expr_gen.sv
// Pseudo-random generator of legal digit/operator/parenthesis expressions,
// one ASCII character per valid/ready transfer.
module expr_gen
  import expr_gen_pkg::*;
#(
  parameter bit          GROUP_EN     = 1'b1,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [3:0]  n_terms,
  input  logic        ready,
  output logic [7:0]  out,
  output logic        valid,
  output logic        last,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshake: a character moves on a rising clk when valid && ready; while
  // valid && !ready, out/last and every register (including the LFSR) hold.

  state_e      state_q, state_d;
  logic [3:0]  terms_q, terms_d;
  logic [2:0]  gcnt_q, gcnt_d;
  logic [15:0] lfsr;
  logic        load, xfer;
  logic [3:0]  nib, dval;
  logic [7:0]  digit, op;
  logic        grp;
  logic [2:0]  glen;

  assign load = (state_q == S_IDLE) && start;
  assign xfer = valid && ready;

  expr_lfsr16 u_lfsr (
    .clk     (clk),
    .clr     (clr),
    .load_i  (load),
    .seed_i  ((seed == 16'h0000) ? SEED_DEFAULT : seed),
    .adv_i   (xfer),
    .state_o (lfsr)
  );

  assign nib   = lfsr[3:0];
  assign dval  = (nib >= 4'd10) ? (nib - 4'd10) : nib;
  assign digit = CH_0 + {4'd0, dval};
  assign op    = lfsr[4] ? CH_STAR : CH_PLUS;
  assign grp   = GROUP_EN & lfsr[5] & lfsr[6];
  assign glen  = {1'b0, lfsr[8:7]} + 3'd1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      terms_q <= 4'd0;
      gcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      terms_q <= terms_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    terms_d = terms_q;
    gcnt_d  = gcnt_q;
    out     = 8'h00;
    valid   = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TERM;
          terms_d = (n_terms == 4'd0) ? 4'd1 : n_terms;
        end
      end
      S_TERM: begin
        valid = 1'b1;
        if (grp) begin
          out = CH_LPAR;
          if (xfer) begin
            gcnt_d  = glen;
            state_d = S_GDIG;
          end
        end else begin
          out  = digit;
          last = (terms_q == 4'd1);
          if (xfer) state_d = last ? S_IDLE : S_OP;
        end
      end
      S_GDIG: begin
        valid = 1'b1;
        out   = digit;
        if (xfer) begin
          gcnt_d  = gcnt_q - 3'd1;
          state_d = (gcnt_q == 3'd1) ? S_GCLOSE : S_GOP;
        end
      end
      S_GOP: begin
        valid = 1'b1;
        out   = op;
        if (xfer) state_d = S_GDIG;
      end
      S_GCLOSE: begin
        valid = 1'b1;
        out   = CH_RPAR;
        last  = (terms_q == 4'd1);
        if (xfer) state_d = last ? S_IDLE : S_OP;
      end
      S_OP: begin
        valid = 1'b1;
        out   = op;
        if (xfer) begin
          terms_d = terms_q - 4'd1;
          state_d = S_TERM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = valid;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_expr_gen.sv
// Bench for expr_gen: a grouped and a flat instance share stimulus; each is
// checked every cycle against an expected character queue built from the grammar rules.
module tb_expr_gen;

  logic        clk, clr, start, ready;
  logic [15:0] seed;
  logic [3:0]  n_terms;
  logic [7:0]  out_g, out_f;
  logic        valid_g, valid_f, last_g, last_f, busy_g, busy_f;
  logic [2:0]  dbg_g, dbg_f;

  int tests = 0;
  int fails = 0;

  logic [7:0] q_grp[$];
  logic [7:0] q_flat[$];
  logic [7:0] act_g[$];
  logic [7:0] act_f[$];
  logic [7:0] done_g[$];
  logic [7:0] done_f[$];

  expr_gen #(.GROUP_EN(1'b1)) u_grp (
    .clk(clk), .clr(clr), .start(start), .seed(seed), .n_terms(n_terms), .ready(ready),
    .out(out_g), .valid(valid_g), .last(last_g), .busy(busy_g), .dbg_state(dbg_g)
  );

  expr_gen #(.GROUP_EN(1'b0)) u_flat (
    .clk(clk), .clr(clr), .start(start), .seed(seed), .n_terms(n_terms), .ready(ready),
    .out(out_f), .valid(valid_f), .last(last_f), .busy(busy_f), .dbg_state(dbg_f)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] m_digit(input logic [15:0] l);
    int v;
    v = int'(l[3:0]) % 10;
    return 8'(8'h30 + v);
  endfunction

  // Whole expected expression, term by term, one LFSR step per character.
  task automatic model_expr(input bit gen, input logic [15:0] sd, input logic [3:0] nt,
                            output logic [7:0] q[$]);
    logic [15:0] l;
    int terms, glen;
    q.delete();
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    terms = (nt == 4'd0) ? 1 : int'(nt);
    for (int t = 0; t < terms; t++) begin
      if (gen && l[5] && l[6]) begin
        glen = int'(l[8:7]) + 1;
        q.push_back("("); l = m_next(l);
        for (int k = 0; k < glen; k++) begin
          q.push_back(m_digit(l)); l = m_next(l);
          if (k < glen - 1) begin
            q.push_back(l[4] ? "*" : "+"); l = m_next(l);
          end
        end
        q.push_back(")"); l = m_next(l);
      end else begin
        q.push_back(m_digit(l)); l = m_next(l);
      end
      if (t < terms - 1) begin
        q.push_back(l[4] ? "*" : "+"); l = m_next(l);
      end
    end
  endtask

  // Recognizer: returns 1 when the string is a complete legal expression.
  function automatic bit legal(input logic [7:0] s[$]);
    int depth;
    bit need_operand;
    depth = 0;
    need_operand = 1'b1;
    if (s.size() == 0) return 1'b0;
    foreach (s[i]) begin
      if (need_operand) begin
        if (s[i] >= "0" && s[i] <= "9") need_operand = 1'b0;
        else if (s[i] == "(" && depth == 0) depth = 1;
        else return 1'b0;
      end else begin
        if (s[i] == "+" || s[i] == "*") need_operand = 1'b1;
        else if (s[i] == ")" && depth == 1) depth = 0;
        else return 1'b0;
      end
    end
    return !need_operand && depth == 0;
  endfunction

  task automatic check_str(input string name, input logic [7:0] act[$], input string exp);
    bit ok;
    string a;
    ok = (act.size() == exp.len());
    a = "";
    foreach (act[i]) begin
      a = {a, string'(act[i])};
      if (ok && act[i] != exp[i]) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, a, exp);
    end
  endtask

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (!clr) begin
      chk("grp_valid", valid_g, q_grp.size() > 0);
      chk("grp_busy", busy_g, valid_g);
      if (q_grp.size() > 0) begin
        chk("grp_out", out_g, q_grp[0]);
        chk("grp_last", last_g, q_grp.size() == 1);
      end
      chk("flat_valid", valid_f, q_flat.size() > 0);
      chk("flat_busy", busy_f, valid_f);
      if (q_flat.size() > 0) begin
        chk("flat_out", out_f, q_flat[0]);
        chk("flat_last", last_f, q_flat.size() == 1);
      end
    end
  end

  // Transfers: pop expectations, collect actual strings, recognise at last.
  always @(posedge clk) begin
    if (!clr && ready) begin
      if (q_grp.size() > 0) void'(q_grp.pop_front());
      if (q_flat.size() > 0) void'(q_flat.pop_front());
      if (valid_g) begin
        act_g.push_back(out_g);
        if (last_g) begin
          chk("grp_legal", legal(act_g), 1);
          chk("grp_len_le_149", act_g.size() <= 149, 1);
          done_g = act_g;
          act_g.delete();
        end
      end
      if (valid_f) begin
        act_f.push_back(out_f);
        if (last_f) begin
          chk("flat_legal", legal(act_f), 1);
          chk("flat_len_le_149", act_f.size() <= 149, 1);
          done_f = act_f;
          act_f.delete();
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic start_expr(input logic [15:0] sd, input logic [3:0] nt);
    start   = 1'b1;
    seed    = sd;
    n_terms = nt;
    @(posedge clk); #1;
    start = 1'b0;
    model_expr(1'b1, sd, nt, q_grp);
    model_expr(1'b0, sd, nt, q_flat);
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n;
    n = 0;
    while ((q_grp.size() > 0 || q_flat.size() > 0) && n < 600) begin
      if (rand_ready) ready = ($urandom_range(0, 7) != 0);
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b1;
    tests++;
    if (n >= 600) begin
      fails++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", q_grp.size() + q_flat.size());
      q_grp.delete();
      q_flat.delete();
      clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1; start = 1'b0; ready = 1'b1; seed = 16'h0; n_terms = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_g, 8'h00);
    chk("rst_valid", valid_g, 0);
    chk("rst_last", last_g, 0);
    chk("rst_busy", busy_f, 0);
    clr = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    start_expr(16'h0003, 4'd1);
    wait_idle(1'b0);
    check_str("flat_seed3_n1", done_f, "3");
    check_str("grp_seed3_n1", done_g, "3");

    start_expr(16'h0003, 4'd2);
    wait_idle(1'b0);
    check_str("flat_seed3_n2", done_f, "3+2");

    start_expr(16'h0060, 4'd1);
    wait_idle(1'b0);
    check_str("grp_seed60", done_g, "(0)");

    start_expr(16'h0000, 4'd1);
    wait_idle(1'b0);
    check_str("flat_seed0_default", done_f, "1");

    // Stall: ready 1,0,0,1,1 after start; a start pulse during busy is ignored
    ready = 1'b1;
    start_expr(16'h0003, 4'd2);
    @(posedge clk); #1;
    ready = 1'b0; start = 1'b1; seed = 16'h0060; n_terms = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("stall_hold_plus", out_f, "+");
    @(posedge clk); #1;
    chk("stall_hold_plus2", out_f, "+");
    ready = 1'b1;
    wait_idle(1'b0);
    check_str("flat_stall", done_f, "3+2");

    // Asynchronous clear mid-group, then a fresh expression
    start_expr(16'h01E0, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    chk("clr_valid_g", valid_g, 0);
    chk("clr_busy_g", busy_g, 0);
    chk("clr_out_g", out_g, 8'h00);
    chk("clr_valid_f", valid_f, 0);
    q_grp.delete(); q_flat.delete(); act_g.delete(); act_f.delete();
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    start_expr(16'h0003, 4'd2);
    wait_idle(1'b0);
    check_str("flat_after_clr", done_f, "3+2");

    // Random soak
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] sd;
      sd = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
      start_expr(sd, 4'($urandom_range(0, 15)));
      wait_idle(1'b1);
    end

    // Longest case: n_terms=15 with ready held high
    start_expr(16'hFFFF, 4'd15);
    wait_idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
